jy_irq_timer: RTL and testbench

JY_IRQ_TIMER -- requirements
Module: jy_irq_timer

---
 rtl/jy_irq_timer.sv | 212 +++++++++++++++++++++
 tb/tb_jy_irq_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jy_irq_timer.sv
// jy_irq_timer: multi-channel 8-bit IRQ timer with selectable tick sources
// (m2, filtered PPU A12 rise, PPU /OE fall, external CPU write). All state
// advances on the falling edge of m2.
module jy_irq_timer #(
  parameter int CH       = 2,
  parameter int NARROW_W = 3,
  parameter int A12_FILT = 0
) (
  input  logic        m2,
  input  logic        map_rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        cpu_rw,
  input  logic        ppu_a12,
  input  logic        ppu_oe,
  output logic        irq,
  output logic [7:0]  rd_dat,
  output logic        rd_oe
);

  localparam logic [7:0] NARROW_MASK = 8'((1 << NARROW_W) - 1);
  localparam logic [3:0] FILT_MIN    = 4'(A12_FILT);

  // Per-channel state
  logic [CH-1:0]      en_q, en_d, pend_q, pend_d;
  logic [CH-1:0][7:0] mode_q, mode_d, pre_q, pre_d, cnt_q, cnt_d;
  logic [CH-1:0][7:0] xor_q, xor_d, rld_q, rld_d;

  // Shared edge detectors and A12 low-run filter
  logic [1:0] a12_sr_q, a12_sr_d, oe_sr_q, oe_sr_d;
  logic [3:0] low_cnt_q, low_cnt_d;
  logic       irq_q, irq_d;

  // Decode helpers
  logic               win_s, ch_ok_s, wr_s, ext_wr_s, rd_hit_s, filt_ok_s;
  logic               a12_rise_s, oe_fall_s;
  logic [2:0]         sel_s, off_s;
  logic [CH-1:0]      tick_s, hit_s, load_wr_s, set_pend_s;
  logic [CH-1:0][7:0] mask_s;
  logic               unused_s;

  assign win_s    = (cpu_addr[15:11] == 5'b11000);
  assign sel_s    = cpu_addr[5:3];
  assign off_s    = cpu_addr[2:0];
  assign ch_ok_s  = ({29'd0, sel_s} < 32'(CH));
  assign wr_s     = ~cpu_rw & win_s & ch_ok_s;
  assign ext_wr_s = ~cpu_rw & ~win_s;
  assign rd_hit_s = cpu_rw & win_s & ch_ok_s & ((off_s == 3'd0) | (off_s == 3'd5));

  // A zero filter threshold means every rise qualifies.
  if (A12_FILT == 0) begin : g_nofilt
    assign filt_ok_s = 1'b1;
  end else begin : g_filt
    assign filt_ok_s = (low_cnt_q >= FILT_MIN);
  end

  assign a12_rise_s = (a12_sr_q == 2'b01) & filt_ok_s;
  assign oe_fall_s  = (oe_sr_q == 2'b10);
  assign irq        = irq_q;
  assign unused_s   = ^{cpu_addr[10:6], low_cnt_q} ^ (^mode_q);

  // Edge-detector shift registers and saturating A12 low-run counter.
  always_comb begin
    a12_sr_d  = {a12_sr_q[0], ppu_a12};
    oe_sr_d   = {oe_sr_q[0], ppu_oe};
    low_cnt_d = low_cnt_q;
    if (a12_sr_q[0]) begin
      low_cnt_d = 4'd0;
    end else if (low_cnt_q != 4'hF) begin
      low_cnt_d = low_cnt_q + 4'd1;
    end else begin
      low_cnt_d = low_cnt_q;
    end
  end

  // Per-channel tick source, prescaler mask and register-write hit decode.
  always_comb begin
    tick_s    = '0;
    hit_s     = '0;
    load_wr_s = '0;
    mask_s    = '0;
    for (int c = 0; c < CH; c++) begin
      case (mode_q[c][1:0])
        2'd0:    tick_s[c] = 1'b1;
        2'd1:    tick_s[c] = a12_rise_s;
        2'd2:    tick_s[c] = oe_fall_s;
        2'd3:    tick_s[c] = ext_wr_s;
        default: tick_s[c] = 1'b0;
      endcase
      mask_s[c]    = mode_q[c][2] ? NARROW_MASK : 8'hFF;
      hit_s[c]     = wr_s & (sel_s == 3'(c));
      load_wr_s[c] = hit_s[c] & ((off_s == 3'd4) | (off_s == 3'd5));
    end
  end

  // Next-state: tick action first, then CPU register writes override it.
  always_comb begin
    en_d       = en_q;
    pend_d     = pend_q;
    mode_d     = mode_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    rld_d      = rld_q;
    set_pend_s = '0;
    for (int c = 0; c < CH; c++) begin
      if (en_q[c] && tick_s[c] && !load_wr_s[c]) begin
        case (mode_q[c][7:6])
          2'b01: begin
            pre_d[c] = pre_q[c] + 8'd1;
            if ((pre_q[c] & mask_s[c]) == mask_s[c]) begin
              set_pend_s[c] = (cnt_q[c] == 8'hFF);
              cnt_d[c] = (set_pend_s[c] && mode_q[c][3]) ? rld_q[c] : cnt_q[c] + 8'd1;
            end else begin
              cnt_d[c] = cnt_q[c];
            end
          end
          2'b10: begin
            pre_d[c] = pre_q[c] - 8'd1;
            if ((pre_q[c] & mask_s[c]) == 8'h00) begin
              set_pend_s[c] = (cnt_q[c] == 8'h00);
              cnt_d[c] = (set_pend_s[c] && mode_q[c][3]) ? rld_q[c] : cnt_q[c] - 8'd1;
            end else begin
              cnt_d[c] = cnt_q[c];
            end
          end
          default: begin
            pre_d[c] = pre_q[c];
          end
        endcase
      end else begin
        pre_d[c] = pre_q[c];
      end
      pend_d[c] = pend_q[c] | set_pend_s[c];

      if (hit_s[c]) begin
        case (off_s)
          3'd0: begin
            if (cpu_dat[7]) begin
              // Ack: a same-cycle terminal step still leaves pending set.
              pend_d[c] = set_pend_s[c];
            end else if (cpu_dat[0]) begin
              en_d[c] = 1'b1;
            end else begin
              en_d[c]   = 1'b0;
              pre_d[c]  = 8'h00;
              pend_d[c] = 1'b0;
            end
          end
          3'd1: mode_d[c] = cpu_dat;
          3'd2: begin
            en_d[c]   = 1'b0;
            pre_d[c]  = 8'h00;
            pend_d[c] = 1'b0;
          end
          3'd3: en_d[c]  = 1'b1;
          3'd4: pre_d[c] = cpu_dat ^ xor_q[c];
          3'd5: cnt_d[c] = cpu_dat ^ xor_q[c];
          3'd6: xor_d[c] = cpu_dat;
          3'd7: rld_d[c] = cpu_dat;
          default: en_d[c] = en_q[c];
        endcase
      end else begin
        en_d[c] = en_q[c];
      end
    end
    irq_d = |pend_d;
  end

  // Combinational register read-back; bus idles at 8'hFF.
  always_comb begin
    rd_oe  = rd_hit_s;
    rd_dat = 8'hFF;
    for (int c = 0; c < CH; c++) begin
      if (rd_hit_s && (sel_s == 3'(c))) begin
        rd_dat = (off_s == 3'd0) ? {pend_q[c], 6'b000000, en_q[c]} : cnt_q[c];
      end else begin
        rd_dat = rd_dat;
      end
    end
  end

  // State registers on the m2 falling edge; reset wins over writes and ticks.
  always_ff @(negedge m2) begin
    if (map_rst) begin
      en_q      <= '0;
      pend_q    <= '0;
      mode_q    <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      xor_q     <= '0;
      rld_q     <= '0;
      a12_sr_q  <= 2'b00;
      oe_sr_q   <= 2'b00;
      low_cnt_q <= 4'd0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      rld_q     <= rld_d;
      a12_sr_q  <= a12_sr_d;
      oe_sr_q   <= oe_sr_d;
      low_cnt_q <= low_cnt_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_jy_irq_timer.sv
// Scoreboard bench for jy_irq_timer: reads push expected {rd_dat, irq},
// a monitor on the m2 rising edge pops and compares whenever rd_oe is high.
module tb_jy_irq_timer;

  logic        m2;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic        ppu_a12;
  logic        ppu_oe;
  logic        irq;
  logic [7:0]  rd_dat;
  logic        rd_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_n    = 0;

  logic [7:0] exp_dat_q [$];
  logic       exp_irq_q [$];
  int         exp_id_q  [$];

  jy_irq_timer #(.CH(2), .NARROW_W(3), .A12_FILT(3)) dut (
    .m2       (m2),
    .map_rst  (map_rst),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .cpu_rw   (cpu_rw),
    .ppu_a12  (ppu_a12),
    .ppu_oe   (ppu_oe),
    .irq      (irq),
    .rd_dat   (rd_dat),
    .rd_oe    (rd_oe)
  );

  // Clock: DUT acts on the falling edge, monitor samples on the rising edge.
  initial begin
    m2 = 1'b1;
    forever #5 m2 = ~m2;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pop and compare on every presented read.
  always @(posedge m2) begin
    logic [7:0] ed;
    logic       ei;
    int         id;
    if (rd_oe === 1'b1) begin
      n_tests++;
      if (exp_dat_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got rd_dat=%h, scoreboard empty", rd_dat);
      end else begin
        ed = exp_dat_q.pop_front();
        ei = exp_irq_q.pop_front();
        id = exp_id_q.pop_front();
        if (rd_dat !== ed || irq !== ei) begin
          n_fail++;
          $display("FAIL read_%0d: got rd_dat=%h irq=%b, expected rd_dat=%h irq=%b",
                   id, rd_dat, irq, ed, ei);
        end
      end
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_rw   = rw;
    @(negedge m2);
    #1;
  endtask

  task automatic wr(input int ch, input int off, input logic [7:0] d);
    cyc(16'hC000 + 16'(ch * 8 + off), d, 1'b0);
  endtask

  task automatic rd(input int ch, input int off, input logic [7:0] ed, input logic ei);
    exp_dat_q.push_back(ed);
    exp_irq_q.push_back(ei);
    exp_id_q.push_back(rd_n);
    rd_n++;
    cyc(16'hC000 + 16'(ch * 8 + off), 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(16'h0000, 8'h00, 1'b1);
  endtask

  // A read that must not be decoded: rd_oe low, bus idles at 8'hFF.
  task automatic idle_chk(input int ch, input int off);
    cpu_addr = 16'hC000 + 16'(ch * 8 + off);
    cpu_rw   = 1'b1;
    cpu_dat  = 8'h00;
    @(posedge m2);
    n_tests++;
    if (rd_oe !== 1'b0 || rd_dat !== 8'hFF) begin
      n_fail++;
      $display("FAIL no_decode_ch%0d_off%0d: got rd_oe=%b rd_dat=%h, expected rd_oe=0 rd_dat=ff",
               ch, off, rd_oe, rd_dat);
    end
    @(negedge m2);
    #1;
  endtask

  initial begin
    map_rst  = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dat  = 8'h00;
    cpu_rw   = 1'b1;
    ppu_a12  = 1'b0;
    ppu_oe   = 1'b1;
    repeat (3) @(negedge m2);
    #1;
    @(posedge m2);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got irq=%b, expected 0", irq);
    end
    @(negedge m2);
    #1;
    map_rst = 1'b0;

    // Reset state and decode boundaries
    rd(0, 0, 8'h00, 1'b0);
    rd(0, 5, 8'h00, 1'b0);
    rd(1, 0, 8'h00, 1'b0);
    idle_chk(2, 0);
    idle_chk(0, 1);

    // ch0 up count from m2: step on 2nd tick, 0xFF -> 0x00 sets pending/irq
    wr(0, 1, 8'h40);
    wr(0, 4, 8'hFE);
    wr(0, 5, 8'hFF);
    wr(0, 3, 8'h00);
    rd(0, 5, 8'hFF, 1'b0);
    rd(0, 5, 8'hFF, 1'b0);
    rd(0, 5, 8'h00, 1'b1);
    rd(0, 0, 8'h81, 1'b1);
    wr(0, 1, 8'h00);

    // ch1 down, narrow prescaler: 01->00 on first tick, terminal 8 ticks later
    wr(1, 1, 8'h84);
    wr(1, 4, 8'h00);
    wr(1, 5, 8'h01);
    wr(1, 3, 8'h00);
    rd(1, 5, 8'h01, 1'b1);
    rd(1, 5, 8'h00, 1'b1);
    idle(6);
    rd(1, 0, 8'h01, 1'b1);
    rd(1, 0, 8'h81, 1'b1);
    rd(1, 5, 8'hFF, 1'b1);
    wr(1, 2, 8'h00);
    rd(1, 0, 8'h00, 1'b1);

    // ack with 0x81: pending cleared, enable kept
    wr(0, 0, 8'h81);
    rd(0, 0, 8'h01, 1'b0);

    // xor on loads; loads drop the same-cycle tick
    wr(0, 1, 8'h40);
    wr(0, 6, 8'h5A);
    wr(0, 4, 8'hA4);
    wr(0, 5, 8'hA5);
    rd(0, 5, 8'hFF, 1'b0);
    rd(0, 5, 8'hFF, 1'b0);
    rd(0, 5, 8'h00, 1'b1);
    rd(0, 0, 8'h81, 1'b1);
    wr(0, 0, 8'h80);
    rd(0, 0, 8'h01, 1'b0);

    // disable clears prescaler: narrow up count steps on 8th tick, not 2nd
    wr(0, 1, 8'h00);
    wr(0, 6, 8'h00);
    wr(0, 4, 8'hF6);
    wr(0, 2, 8'h00);
    wr(0, 5, 8'hFF);
    wr(0, 1, 8'h44);
    wr(0, 3, 8'h00);
    rd(0, 5, 8'hFF, 1'b0);
    idle(6);
    rd(0, 5, 8'hFF, 1'b0);
    rd(0, 5, 8'h00, 1'b1);
    wr(0, 2, 8'h00);
    rd(0, 0, 8'h00, 1'b0);

    // ch1 filtered A12 source with auto-reload
    ppu_a12 = 1'b1;
    wr(1, 1, 8'h49);
    wr(1, 7, 8'hF0);
    wr(1, 4, 8'hFF);
    wr(1, 5, 8'hFF);
    wr(1, 3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ppu_a12 = 1'b0;
      idle(1);
      ppu_a12 = 1'b1;
      idle(1);
    end
    ppu_a12 = 1'b0;
    idle(2);
    ppu_a12 = 1'b1;
    idle(1);
    rd(1, 5, 8'hFF, 1'b0);
    ppu_a12 = 1'b0;
    idle(3);
    ppu_a12 = 1'b1;
    idle(1);
    rd(1, 5, 8'hFF, 1'b0);
    rd(1, 5, 8'hF0, 1'b1);
    rd(1, 0, 8'h81, 1'b1);

    // reset mid-count, colliding with a write
    wr(1, 6, 8'h3C);
    wr(0, 1, 8'h40);
    wr(0, 3, 8'h00);
    idle(3);
    map_rst = 1'b1;
    wr(0, 5, 8'h33);
    map_rst = 1'b0;
    rd(0, 0, 8'h00, 1'b0);
    rd(0, 5, 8'h00, 1'b0);
    rd(1, 0, 8'h00, 1'b0);
    rd(1, 5, 8'h00, 1'b0);
    wr(1, 5, 8'h12);
    rd(1, 5, 8'h12, 1'b0);
    wr(2, 5, 8'h77);
    rd(0, 5, 8'h00, 1'b0);
    rd(1, 5, 8'h12, 1'b0);

    idle(2);
    n_tests++;
    if (exp_dat_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d reads outstanding, expected 0", exp_dat_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
